// File: rtl/seq_bubble_sorter.sv
// ---------------------------------------------------------------------------
// seq_bubble_sorter
//   Sequential frame sorter. A frame of DEPTH unsigned words is loaded over a
//   valid/ready stream. The frame is then sorted in place by odd-even
//   transposition, applying one phase per clock for DEPTH clocks. The sorted
//   frame is streamed out on a second valid/ready port, and out_last marks the
//   final word.
//
//   Loading, sorting and draining are mutually exclusive states. Words are
//   therefore never accepted and emitted in the same cycle.
//
// Parameters
//   WIDTH    bits per element (unsigned compare)
//   DEPTH    elements per frame, >= 2
//   DESCEND  0 = ascending output order, 1 = descending
//
// Ports
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset; aborts any frame in progress
//   in_valid   producer offers in_data
//   in_ready   sorter accepts a word (LOAD state)
//   in_data    element to load
//   out_valid  out_data holds a sorted element (DRAIN state)
//   out_ready  consumer takes out_data
//   out_data   sorted element at read index (0 when not draining)
//   out_last   high with the final element of the frame
//   busy       frame in progress (any word loaded, or sorting/draining)
// ---------------------------------------------------------------------------
module seq_bubble_sorter #(
    parameter int WIDTH   = 3,
    parameter int DEPTH   = 8,
    parameter int DESCEND = 0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_last,
    output logic             busy
);

    // Counters carry one spare bit. Array indices use only the low AW bits.
    localparam int CW = $clog2(DEPTH) + 1;
    localparam int AW = $clog2(DEPTH);
    localparam logic [CW-1:0] LAST = CW'(DEPTH - 1);

    typedef enum logic [1:0] {
        LOAD  = 2'd0,
        SORT  = 2'd1,
        DRAIN = 2'd2
    } state_t;

    state_t          state;
    logic [CW-1:0]   wr_ptr;
    logic [CW-1:0]   rd_ptr;
    logic [CW-1:0]   ph;
    logic [WIDTH-1:0] a      [DEPTH];
    logic [WIDTH-1:0] sorted [DEPTH];

    // One transposition phase. Even phases pair (0,1),(2,3)...; odd phases
    // pair (1,2),(3,4)... Pairs within a phase never overlap, so all
    // compare/swaps can be evaluated in parallel. Equal values never swap,
    // which keeps the sort stable.
    always_comb begin
        // NOTE: the whole array gets a default copy first. Each element is then
        // assigned on every path, so no latch is inferred.
        sorted = a;
        for (int i = 0; i < DEPTH - 1; i++) begin
            if (i[0] == ph[0]) begin
                if ((DESCEND != 0) ? (a[i] < a[i+1]) : (a[i] > a[i+1])) begin
                    sorted[i]   = a[i+1];
                    sorted[i+1] = a[i];
                end
            end
        end
    end

    // Handshake outputs decode straight from the state register.
    assign in_ready  = (state == LOAD);
    assign out_valid = (state == DRAIN);
    assign out_data  = out_valid ? a[rd_ptr[AW-1:0]] : '0;
    assign out_last  = out_valid && (rd_ptr == LAST);
    assign busy      = (state != LOAD) || (wr_ptr != '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= LOAD;
            wr_ptr <= '0;
            rd_ptr <= '0;
            ph     <= '0;
            // NOTE: the element array is reset as well as the control state.
            // This makes out_data and the array contents defined straight out
            // of reset and after an aborted frame.
            for (int i = 0; i < DEPTH; i++) begin
                a[i] <= '0;
            end
        end else begin
            // NOTE: all sequential state uses non-blocking assignments. Every
            // read in this block therefore sees pre-edge values.
            case (state)
                LOAD: begin
                    if (in_valid) begin
                        a[wr_ptr[AW-1:0]] <= in_data;
                        if (wr_ptr == LAST) begin
                            wr_ptr <= '0;
                            ph     <= '0;
                            state  <= SORT;
                        end else begin
                            wr_ptr <= wr_ptr + 1'b1;
                        end
                    end
                end

                SORT: begin
                    for (int i = 0; i < DEPTH; i++) begin
                        a[i] <= sorted[i];
                    end
                    // DEPTH phases of odd-even transposition fully sort DEPTH words.
                    if (ph == LAST) begin
                        ph    <= '0;
                        state <= DRAIN;
                    end else begin
                        ph <= ph + 1'b1;
                    end
                end

                DRAIN: begin
                    if (out_ready) begin
                        if (rd_ptr == LAST) begin
                            rd_ptr <= '0;
                            state  <= LOAD;
                        end else begin
                            rd_ptr <= rd_ptr + 1'b1;
                        end
                    end
                end

                default: begin
                    state <= LOAD;
                end
            endcase
        end
    end

endmodule
